// File: rtl/rpn_op_feeder.sv
// rpn_op_feeder: keys OpA, OpB, OpCode and an Ack press into the RPN calculator's DataIn/Enter port.
// Define FEEDER_TIMEOUT_EN to add a watchdog on the RELEASE wait that aborts with an error pulse.
//
// state   | meaning
// IDLE    | waiting for start; DataOut holds its last value, Enter low
// SETUP   | DataOut valid, Enter low for SETUP_CYC cycles
// PRESS   | Enter high for HOLD_CYC cycles, DataOut stable
// RELEASE | Enter low, waiting for calculator Status to advance
// CAPTURE | latch displayed result and flags after the opcode entry
module rpn_op_feeder #(
  parameter int N           = 16,
  parameter int SETUP_CYC   = 2,
  parameter int HOLD_CYC    = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] opa_in,
  input  logic [N-1:0] opb_in,
  input  logic [1:0]   opcode_in,
  input  logic [2:0]   calc_status,
  input  logic [N-1:0] calc_display,
  input  logic [4:0]   calc_flags,
  output logic [N-1:0] DataOut,
  output logic         EnterOut,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [N-1:0] result,
  output logic [4:0]   result_flags
);

  localparam int CNT_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    PRESS   = 3'd2,
    RELEASE = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  state_t           state_q;
  logic [1:0]       step_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     opb_q;
  logic [1:0]       opcode_q;
  logic [N-1:0]     data_q;
  logic [N-1:0]     result_q;
  logic [4:0]       flags_q;
  logic             enter_q;
  logic             busy_q;
  logic             done_q;

  logic [2:0]       expect_status_d;
  logic             status_match_d;
  logic [N-1:0]     next_data_d;

`ifdef FEEDER_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_q;
  logic            error_q;

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Status expected after the press of the current step; the Ack step wraps to 0.
  always_comb begin
    expect_status_d = {1'b0, 2'(step_q + 2'd1)};
    status_match_d  = (calc_status == expect_status_d);
    next_data_d     = (step_q == 2'd0) ? opb_q : {{(N-2){1'b0}}, opcode_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= 2'd0;
      cnt_q    <= '0;
      opb_q    <= '0;
      opcode_q <= 2'd0;
      data_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      enter_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      wd_q     <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      error_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            opb_q    <= opb_in;
            opcode_q <= opcode_in;
            data_q   <= opa_in;
            step_q   <= 2'd0;
            cnt_q    <= SETUP_LOAD;
            busy_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            enter_q <= 1'b1;
            cnt_q   <= HOLD_LOAD;
            state_q <= PRESS;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        PRESS: begin
          if (cnt_q == '0) begin
            enter_q <= 1'b0;
            state_q <= RELEASE;
`ifdef FEEDER_TIMEOUT_EN
            wd_q    <= WD_LOAD;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RELEASE: begin
          if (status_match_d) begin
            case (step_q)
              2'd3: begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end
              2'd2: state_q <= CAPTURE;
              default: begin
                step_q  <= step_q + 2'd1;
                data_q  <= next_data_d;
                cnt_q   <= SETUP_LOAD;
                state_q <= SETUP;
              end
            endcase
          end
`ifdef FEEDER_TIMEOUT_EN
          else if (wd_q == '0) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            wd_q <= wd_q - WD_W'(1);
          end
`endif
        end
        CAPTURE: begin
          result_q <= calc_display;
          flags_q  <= calc_flags;
          step_q   <= 2'd3;
          cnt_q    <= SETUP_LOAD;
          state_q  <= SETUP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DataOut      = data_q;
  assign EnterOut     = enter_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign result_flags = flags_q;

endmodule

// File: tb/tb_rpn_op_feeder.sv
// Directed bench for rpn_op_feeder: two instances (default timing and 1/1 timing) each driving a small calculator model.
// Calculator model advances Status on each Enter rising edge, so every RELEASE wait is one cycle.
module tb_rpn_op_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  // ---------------- default-timing instance ----------------
  logic        start = 1'b0;
  logic [15:0] opa = '0, opb = '0;
  logic [1:0]  opc = '0;
  logic [2:0]  m_status;
  logic [15:0] m_disp;
  logic [4:0]  m_flags;
  logic [15:0] DataOut, result;
  logic        EnterOut, busy, done, error;
  logic [4:0]  result_flags;
  logic        m_stall = 1'b0;

  rpn_op_feeder #(.N(16), .SETUP_CYC(2), .HOLD_CYC(4), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .reset(reset), .start(start), .opa_in(opa), .opb_in(opb), .opcode_in(opc),
    .calc_status(m_status), .calc_display(m_disp), .calc_flags(m_flags),
    .DataOut(DataOut), .EnterOut(EnterOut), .busy(busy), .done(done), .error(error),
    .result(result), .result_flags(result_flags));

  // ---------------- fast-timing instance ----------------
  logic        f_start = 1'b0;
  logic [15:0] f_opa = '0, f_opb = '0;
  logic [1:0]  f_opc = '0;
  logic [2:0]  f_status;
  logic [15:0] f_disp;
  logic [4:0]  f_flags;
  logic [15:0] f_DataOut, f_result;
  logic        f_EnterOut, f_busy, f_done, f_error;
  logic [4:0]  f_result_flags;

  rpn_op_feeder #(.N(16), .SETUP_CYC(1), .HOLD_CYC(1), .TIMEOUT_CYC(255)) dut_f (
    .clk(clk), .reset(reset), .start(f_start), .opa_in(f_opa), .opb_in(f_opb), .opcode_in(f_opc),
    .calc_status(f_status), .calc_display(f_disp), .calc_flags(f_flags),
    .DataOut(f_DataOut), .EnterOut(f_EnterOut), .busy(f_busy), .done(f_done), .error(f_error),
    .result(f_result), .result_flags(f_result_flags));

  // flags = {carry, overflow, negative, zero, 0}
  function automatic logic [20:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    logic [16:0] w;
    logic        v;
    w = '0;
    v = 1'b0;
    case (op)
      2'd0: begin w = {1'b0, a} + {1'b0, b}; v = (a[15] == b[15]) && (w[15] != a[15]); end
      2'd1: begin w = {1'b0, a} - {1'b0, b}; v = (a[15] != b[15]) && (w[15] != a[15]); end
      2'd2: w = {1'b0, a & b};
      default: w = {1'b0, a | b};
    endcase
    return {w[15:0], w[16], v, w[15], (w[15:0] == 16'd0), 1'b0};
  endfunction

  logic        m_prev;
  logic [15:0] m_a, m_b;
  always @(posedge clk) begin
    if (reset) begin
      m_status <= 3'd0; m_prev <= 1'b0; m_a <= '0; m_b <= '0; m_disp <= '0; m_flags <= '0;
    end else begin
      m_prev <= EnterOut;
      if (EnterOut && !m_prev && !(m_stall && m_status == 3'd1)) begin
        case (m_status)
          3'd0: begin m_a <= DataOut; m_status <= 3'd1; end
          3'd1: begin m_b <= DataOut; m_status <= 3'd2; end
          3'd2: begin {m_disp, m_flags} <= alu(m_a, m_b, DataOut[1:0]); m_status <= 3'd3; end
          default: m_status <= 3'd0;
        endcase
      end
    end
  end

  logic        f_prev;
  logic [15:0] f_a, f_b;
  always @(posedge clk) begin
    if (reset) begin
      f_status <= 3'd0; f_prev <= 1'b0; f_a <= '0; f_b <= '0; f_disp <= '0; f_flags <= '0;
    end else begin
      f_prev <= f_EnterOut;
      if (f_EnterOut && !f_prev) begin
        case (f_status)
          3'd0: begin f_a <= f_DataOut; f_status <= 3'd1; end
          3'd1: begin f_b <= f_DataOut; f_status <= 3'd2; end
          3'd2: begin {f_disp, f_flags} <= alu(f_a, f_b, f_DataOut[1:0]); f_status <= 3'd3; end
          default: f_status <= 3'd0;
        endcase
      end
    end
  end

  // Enter monitors: data at each rising edge, high-run lengths, DataOut changes while pressed.
  logic [15:0] rise_q[$];
  int          hi_runs[$];
  int          chg_cnt = 0;
  logic        mon_prev = 1'b0;
  logic [15:0] mon_prev_data = '0;
  int          mon_run = 0;
  always @(negedge clk) begin
    if (EnterOut === 1'b1) begin
      if (!mon_prev) begin rise_q.push_back(DataOut); mon_run = 1; end
      else begin mon_run++; if (DataOut !== mon_prev_data) chg_cnt++; end
    end else if (mon_prev) hi_runs.push_back(mon_run);
    mon_prev = (EnterOut === 1'b1);
    mon_prev_data = DataOut;
  end

  int   f_rises = 0;
  int   f_runs[$];
  logic f_mon_prev = 1'b0;
  int   f_mon_run = 0;
  always @(negedge clk) begin
    if (f_EnterOut === 1'b1) begin
      if (!f_mon_prev) begin f_rises++; f_mon_run = 1; end
      else f_mon_run++;
    end else if (f_mon_prev) f_runs.push_back(f_mon_run);
    f_mon_prev = (f_EnterOut === 1'b1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Returns the cycle (start cycle = 0) in which done is seen, or -1 on budget expiry.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op, output int lat);
    opa = a; opb = b; opc = op; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 300) begin tick(); lat++; end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_total++; if (DataOut !== 16'h0)   $display("FAIL reset_dataout got %h want 0000", DataOut); else n_pass++;
    n_total++; if (EnterOut !== 1'b0)   $display("FAIL reset_enter got %b want 0", EnterOut); else n_pass++;
    n_total++; if (busy !== 1'b0)       $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0)       $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_total++; if (error !== 1'b0)      $display("FAIL reset_error got %b want 0", error); else n_pass++;
    n_total++; if (result !== 16'h0)    $display("FAIL reset_result got %h want 0000", result); else n_pass++;
    n_total++; if (result_flags !== 5'h0) $display("FAIL reset_flags got %b want 00000", result_flags); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add_basic();
    int lat, r0, h0, c0, bad;
    r0 = rise_q.size(); h0 = hi_runs.size(); c0 = chg_cnt;
    run_op(16'h0005, 16'h0003, 2'd0, lat);
    n_total++; if (lat !== 30) $display("FAIL add_latency got %0d want 30", lat); else n_pass++;
    n_total++; if (result !== 16'h0008) $display("FAIL add_result got %h want 0008", result); else n_pass++;
    n_total++; if (result_flags !== 5'b00000) $display("FAIL add_flags got %b want 00000", result_flags); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL add_busy_at_done got %b want 0", busy); else n_pass++;
    n_total++; if (rise_q.size() - r0 !== 4) $display("FAIL add_presses got %0d want 4", rise_q.size() - r0); else n_pass++;
    bad = 0;
    for (int i = h0; i < hi_runs.size(); i++) if (hi_runs[i] != 4) bad++;
    n_total++; if (bad !== 0 || hi_runs.size() - h0 !== 4) $display("FAIL add_hold_len got %0d bad of %0d want 0 of 4", bad, hi_runs.size() - h0); else n_pass++;
    n_total++; if (rise_q.size() < r0 + 3 || rise_q[r0] !== 16'h0005 || rise_q[r0+1] !== 16'h0003 || rise_q[r0+2] !== 16'h0000)
      $display("FAIL add_dataout_seq got %0d presses want 0005,0003,0000", rise_q.size() - r0);
    else n_pass++;
    n_total++; if (chg_cnt - c0 !== 0) $display("FAIL add_data_stable got %0d changes want 0", chg_cnt - c0); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0) $display("FAIL add_done_pulse got %b want 0", done); else n_pass++;
  endtask

  task automatic test_overflow();
    int lat;
    run_op(16'h7FFF, 16'h0001, 2'd0, lat);
    n_total++; if (lat !== 30) $display("FAIL ovf_latency got %0d want 30", lat); else n_pass++;
    n_total++; if (result !== 16'h8000) $display("FAIL ovf_result got %h want 8000", result); else n_pass++;
    n_total++; if (result_flags !== 5'b01100) $display("FAIL ovf_flags got %b want 01100", result_flags); else n_pass++;
    n_total++; if (error !== 1'b0) $display("FAIL ovf_error got %b want 0", error); else n_pass++;
    tick();
  endtask

  task automatic test_start_while_busy();
    int n_done;
    opa = 16'h0010; opb = 16'h0020; opc = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    opa = 16'h1111; opb = 16'h2222; opc = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    repeat (80) begin tick(); if (done === 1'b1) n_done++; end
    n_total++; if (n_done !== 1) $display("FAIL busy_start_done_count got %0d want 1", n_done); else n_pass++;
    n_total++; if (result !== 16'h0030) $display("FAIL busy_start_result got %h want 0030", result); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL busy_start_idle got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_press();
    int r0, k, lat;
    r0 = rise_q.size();
    opa = 16'h0009; opb = 16'h0004; opc = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (rise_q.size() < r0 + 2 && k < 100) begin tick(); k++; end
    n_total++; if (rise_q.size() < r0 + 2) $display("FAIL midrst_wait_press2 got %0d presses want 2", rise_q.size() - r0); else n_pass++;
    n_total++; if (EnterOut !== 1'b1) $display("FAIL midrst_in_press got %b want 1", EnterOut); else n_pass++;
    reset = 1'b1;
    tick();
    n_total++; if (EnterOut !== 1'b0) $display("FAIL midrst_enter got %b want 0", EnterOut); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
    n_total++; if (result !== 16'h0000) $display("FAIL midrst_result got %h want 0000", result); else n_pass++;
    n_total++; if (DataOut !== 16'h0000) $display("FAIL midrst_dataout got %h want 0000", DataOut); else n_pass++;
    reset = 1'b0;
    tick();
    run_op(16'h0009, 16'h0004, 2'd1, lat);
    n_total++; if (lat !== 30) $display("FAIL midrst_rerun_latency got %0d want 30", lat); else n_pass++;
    n_total++; if (result !== 16'h0005) $display("FAIL midrst_rerun_result got %h want 0005", result); else n_pass++;
    tick();
  endtask

  task automatic test_stalled_status();
    int h0, k, n_done, n_err;
    h0 = hi_runs.size();
    m_stall = 1'b1;
    opa = 16'h00AA; opb = 16'h0055; opc = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (hi_runs.size() < h0 + 2 && k < 100) begin tick(); k++; end
    n_total++; if (hi_runs.size() < h0 + 2) $display("FAIL stall_wait_release2 got %0d releases want 2", hi_runs.size() - h0); else n_pass++;
`ifdef FEEDER_TIMEOUT_EN
    k = 0; n_done = 0;
    while (error !== 1'b1 && k < 50) begin tick(); k++; if (done === 1'b1) n_done++; end
    n_total++; if (k !== 10) $display("FAIL timeout_delay got %0d want 10", k); else n_pass++;
    n_total++; if (busy !== 1'b0 || EnterOut !== 1'b0) $display("FAIL timeout_idle got busy=%b enter=%b want 0 0", busy, EnterOut); else n_pass++;
    n_total++; if (result !== 16'h0005) $display("FAIL timeout_result_kept got %h want 0005", result); else n_pass++;
    tick();
    n_total++; if (error !== 1'b0) $display("FAIL timeout_error_pulse got %b want 0", error); else n_pass++;
    repeat (30) begin tick(); if (done === 1'b1) n_done++; end
    n_total++; if (n_done !== 0) $display("FAIL timeout_no_done got %0d want 0", n_done); else n_pass++;
`else
    n_done = 0; n_err = 0;
    repeat (60) begin tick(); if (done === 1'b1) n_done++; if (error === 1'b1) n_err++; end
    n_total++; if (n_err !== 0) $display("FAIL stall_error got %0d pulses want 0", n_err); else n_pass++;
    n_total++; if (n_done !== 0) $display("FAIL stall_done got %0d pulses want 0", n_done); else n_pass++;
    n_total++; if (busy !== 1'b1 || EnterOut !== 1'b0) $display("FAIL stall_waiting got busy=%b enter=%b want 1 0", busy, EnterOut); else n_pass++;
    n_total++; if (result !== 16'h0005) $display("FAIL stall_result_kept got %h want 0005", result); else n_pass++;
`endif
    m_stall = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fast_timing();
    int lat, r0, h0, bad;
    r0 = f_rises; h0 = f_runs.size();
    f_opa = 16'h1234; f_opb = 16'h0F0F; f_opc = 2'd2; f_start = 1'b1;
    tick();
    f_start = 1'b0;
    lat = 1;
    while (f_done !== 1'b1 && lat < 200) begin tick(); lat++; end
    n_total++; if (f_done !== 1'b1 || lat !== 14) $display("FAIL fast_latency got %0d want 14", lat); else n_pass++;
    n_total++; if (f_rises - r0 !== 4) $display("FAIL fast_rises got %0d want 4", f_rises - r0); else n_pass++;
    bad = 0;
    for (int i = h0; i < f_runs.size(); i++) if (f_runs[i] != 1) bad++;
    n_total++; if (bad !== 0 || f_runs.size() - h0 !== 4) $display("FAIL fast_hold_len got %0d bad of %0d want 0 of 4", bad, f_runs.size() - h0); else n_pass++;
    n_total++; if (f_result !== 16'h0204) $display("FAIL fast_result got %h want 0204", f_result); else n_pass++;
    n_total++; if (f_busy !== 1'b0) $display("FAIL fast_busy got %b want 0", f_busy); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_overflow();
    test_start_while_busy();
    test_reset_mid_press();
    test_stalled_status();
    test_fast_timing();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
